fpu_add_sched: RTL and testbench
================================

Name: fpu_add_sched

Overview:
- Sequencer and arbiter that shares one floating-point adder datapath between two requesters.
- Accepts operand bundles over valid/ready handshakes and grants one request at a time, round-robin.
- Drives registered operand, sub and rounding-mode fields into the adder.
- Waits a fixed settle latency, captures the adder result, then returns it with the requester ID over a valid/ready response port.

Parameters:
- LAT, 1, cycles the adder needs to settle after its operand registers update; legal range 1..15.
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rq_valid  in  2  request valid, one bit per requester
- rq_ready  out  2  request accepted this cycle, one-hot or zero
- rq_a  in  2x69  operand A per requester, packed as {sa, ea[10:0], fa[52:0], fla[3:0]}
- rq_b  in  2x69  operand B per requester, same packing
- rq_sub  in  2  subtract select per requester
- rq_rm  in  2x2  rounding mode per requester
- add_a  out  69  registered operand A to the adder
- add_b  out  69  registered operand B to the adder
- add_sub  out  1  registered subtract select
- add_rm  out  2  registered rounding mode
- add_es  in  11  adder exponent result
- add_fs  in  57  adder significand result
- add_ss  in  1  adder sign result
- add_fls  in  58  adder flag result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  requester that owns the response
- rsp_es  out  11  captured exponent
- rsp_fs  out  57  captured significand
- rsp_ss  out  1  captured sign
- rsp_fls  out  58  captured flags
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - All registered outputs go to 0: add_a, add_b, add_sub, add_rm, rsp_valid, rsp_id, all rsp_* fields.
  - FSM goes to IDLE; settle counter and RR pointer go to 0, so requester 0 has priority first.
  - Asserting reset mid-operation discards the in-flight operation and any held response; nothing is replayed.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Grant logic is combinational.
    - Exactly one rq_valid high: that requester is granted.
    - Both high: the requester the RR pointer selects is granted.
  - rq_ready[g] = 1 for the granted requester only; rq_ready = 0 in EXEC and DONE.
  - On an accept edge:
    - latch rq_a[g], rq_b[g], rq_sub[g], rq_rm[g] into the add_* registers;
    - latch g into rsp_id;
    - set the RR pointer to ~g;
    - load the counter with LAT-1;
    - go to EXEC.
- EXEC:
  - add_* are held stable.
  - Counter nonzero: decrement.
  - Counter zero: capture add_es, add_fs, add_ss, add_fls into rsp_*, set rsp_valid = 1, go to DONE.
- DONE:
  - rsp_valid and all rsp_* fields are held stable until rsp_valid && rsp_ready at an edge.
  - On that edge: rsp_valid goes to 0, FSM goes to IDLE.
  - No new request is accepted in the same cycle; there is no bypass.
- Latency: accept edge k, result captured at edge k+LAT, rsp_valid high from k+LAT. Minimum issue interval is LAT+2 cycles.
- The RR pointer changes only on an accept. A requester that drops rq_valid before it is granted loses nothing.
- Requesters must hold rq_valid and their payload until rq_ready; the block does not check this.
- rsp_ready is ignored outside DONE.
- The add_* outputs keep the last operands after completion; they do not return to 0.
- The NaN payload input to the adder is generated outside this block.

Decomposition:
- Shared package fpu_pkg:
  - operand bundle typedef (69 bits) with field offsets;
  - result bundle typedef {es, fs, ss, fls};
  - FSM state enum;
  - RM encodings.
- One sub-module rr_arb2: 2-way round-robin grant with pointer update on accept.
- The FSM, counter and capture registers stay in the top module.

Test Plan:
- Single request, LAT=1:
  - Stimulus: rq_valid=01, rq_a = 1.0 (ea=0x3FF, fa=1<<52), rq_b likewise, rq_sub=0, RM=00.
  - Required response: rq_ready=01 for one cycle, add_a valid the next cycle, rsp_valid 1 cycle after accept with rsp_id=0, and rsp_* equal to the adder model's result for 2.0.
- Simultaneous requests:
  - Stimulus: rq_valid=11 held, rsp_ready=1.
  - Required response: grants go 0, 1, 0, 1 and rsp_id alternates to match.
- Back-pressure:
  - Stimulus: rsp_ready=0 for 5 cycles in DONE while rq_valid=11.
  - Required response: rsp_* stable, rq_ready=00 throughout, busy=1; on rsp_ready=1, IDLE follows and the next grant goes to the other requester.
- LAT=4:
  - Stimulus: one accept at edge k.
  - Required response: rsp_valid rises exactly at edge k+4; add_* unchanged during EXEC even though rq_a changes.
- Reset mid-op:
  - Stimulus: assert rst_n=0 asynchronously while in EXEC, then in DONE.
  - Required response: rsp_valid=0 and busy=0 immediately, all outputs 0, and after release requester 0 is granted first.
- Subtract path:
  - Stimulus: rq_sub[1]=1 with a=b=3.0, RM=11.
  - Required response: add_sub=1, and rsp_* matches the adder model's zero result for that rounding mode (sign and ZERO flag).

Source files
------------

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared types and constants for the adder scheduler slice.
//   fpu_op_t      : 69-bit operand bundle {sa, ea[10:0], fa[52:0], fla[3:0]}
//   fpu_res_t     : adder result bundle {es, fs, ss, fls}
//   sched_state_t : scheduler FSM states
//   RM_*          : rounding-mode encodings carried on rq_rm / add_rm
// ---------------------------------------------------------------------------
package fpu_pkg;

   localparam int OP_W    = 69;
   localparam int FLA_LSB = 0;
   localparam int FA_LSB  = 4;
   localparam int EA_LSB  = 57;
   localparam int SA_BIT  = 68;

   localparam int ES_W  = 11;
   localparam int FS_W  = 57;
   localparam int FLS_W = 58;

   // Settle counter width; covers LAT up to 15.
   localparam int CNT_W = 4;

   // Bit of the adder flag word that marks an exact-zero result.
   localparam int FLS_ZERO = 0;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   typedef struct packed {
      logic        sa;
      logic [10:0] ea;
      logic [52:0] fa;
      logic [3:0]  fla;
   } fpu_op_t;

   typedef struct packed {
      logic [ES_W-1:0]  es;
      logic [FS_W-1:0]  fs;
      logic             ss;
      logic [FLS_W-1:0] fls;
   } fpu_res_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } sched_state_t;

endpackage

// File: rtl/fpu_add_sched_if.sv
// ---------------------------------------------------------------------------
// fpu_add_sched_if
// Bundles the request port, the adder datapath port and the response port of
// fpu_add_sched.
//   slave  : the scheduler side (drives rq_ready, add_*, rsp_*, busy)
//   master : the environment side (requesters, adder, response consumer)
//
// Handshake rule for both the request and the response port: a transfer
// happens at a rising clock edge where valid and ready are both high. The
// sender holds valid and its payload stable until that edge; ready may depend
// combinationally on valid, valid never depends on ready.
// ---------------------------------------------------------------------------
interface fpu_add_sched_if;
   import fpu_pkg::*;

   logic [1:0]             rq_valid;
   logic [1:0]             rq_ready;
   logic [1:0][OP_W-1:0]   rq_a;
   logic [1:0][OP_W-1:0]   rq_b;
   logic [1:0]             rq_sub;
   logic [1:0][1:0]        rq_rm;

   logic [OP_W-1:0]        add_a;
   logic [OP_W-1:0]        add_b;
   logic                   add_sub;
   logic [1:0]             add_rm;
   logic [ES_W-1:0]        add_es;
   logic [FS_W-1:0]        add_fs;
   logic                   add_ss;
   logic [FLS_W-1:0]       add_fls;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_id;
   logic [ES_W-1:0]        rsp_es;
   logic [FS_W-1:0]        rsp_fs;
   logic                   rsp_ss;
   logic [FLS_W-1:0]       rsp_fls;

   logic                   busy;
   sched_state_t           state_dbg;

   modport slave (
      input  rq_valid, rq_a, rq_b, rq_sub, rq_rm,
      input  add_es, add_fs, add_ss, add_fls,
      input  rsp_ready,
      output rq_ready,
      output add_a, add_b, add_sub, add_rm,
      output rsp_valid, rsp_id, rsp_es, rsp_fs, rsp_ss, rsp_fls,
      output busy, state_dbg
   );

   modport master (
      output rq_valid, rq_a, rq_b, rq_sub, rq_rm,
      output add_es, add_fs, add_ss, add_fls,
      output rsp_ready,
      input  rq_ready,
      input  add_a, add_b, add_sub, add_rm,
      input  rsp_valid, rsp_id, rsp_es, rsp_fs, rsp_ss, rsp_fls,
      input  busy, state_dbg
   );

endinterface

// File: rtl/fpu_add_sched_arb.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Grant is combinational from req while en is
// high; the priority pointer moves only when a grant is actually issued, so a
// requester that withdraws before being granted keeps its turn.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   en         : arbitration enabled this cycle
//   req[1:0]   : request lines
//   gnt[1:0]   : one-hot grant or zero
//   gnt_id     : index of the granted requester (0 when no grant)
// ---------------------------------------------------------------------------
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   // Requester that wins when both are asking.
   logic ptr_q;

   always_comb begin
      gnt    = 2'b00;
      gnt_id = 1'b0;
      if (en) begin
         case (req)
            2'b01: begin
               gnt    = 2'b01;
               gnt_id = 1'b0;
            end
            2'b10: begin
               gnt    = 2'b10;
               gnt_id = 1'b1;
            end
            2'b11: begin
               gnt_id = ptr_q;
               gnt    = ptr_q ? 2'b10 : 2'b01;
            end
            default: ;
         endcase
      end
   end

   // The winner gets lowest priority on the next contested cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else if (gnt != 2'b00) begin
         ptr_q <= ~gnt_id;
      end
   end

endmodule

// File: rtl/fpu_add_sched.sv
// ---------------------------------------------------------------------------
// fpu_add_sched
// Shares one floating-point adder between two requesters. One request is
// granted at a time (round-robin), its operands are registered onto add_*,
// the adder is given LAT cycles to settle, then the result is captured and
// offered on the response port tagged with the requester id.
//   clk, rst_n : clock, asynchronous active-low reset
//   sif        : request port, adder port, response port, busy, state_dbg
// Parameters:
//   LAT  : adder settle cycles after add_* update, 1..15
//   NREQ : number of requesters, 2 in this revision
// Timing: accept at edge k, capture and rsp_valid at edge k+LAT, response
// handshake returns to IDLE; next accept one edge later at the earliest.
// ---------------------------------------------------------------------------
module fpu_add_sched
   import fpu_pkg::*;
#(
   parameter int LAT  = 1,
   parameter int NREQ = 2
) (
   input logic            clk,
   input logic            rst_n,
   fpu_add_sched_if.slave sif
);

   // Counter starts at LAT-1 so the capture lands exactly LAT edges after accept.
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

   sched_state_t     state_q;
   sched_state_t     state_d;

   logic [NREQ-1:0]  gnt;
   logic             gnt_id;
   logic             accept;
   logic             idle;

   logic [CNT_W-1:0] cnt_q;
   fpu_op_t          a_q;
   fpu_op_t          b_q;
   logic             sub_q;
   logic [1:0]       rm_q;

   logic             rsp_valid_q;
   logic             rsp_id_q;
   fpu_res_t         res_q;

   assign idle = (state_q == ST_IDLE);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (idle),
      .req    (sif.rq_valid),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Grant is only produced in IDLE, so any grant is an accept.
   assign accept = (gnt != '0);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (cnt_q == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            // rsp_valid is always high here, so rsp_ready alone completes it.
            if (sif.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- operand, counter and result registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sub_q       <= 1'b0;
         rm_q        <= 2'b00;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         res_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  a_q      <= sif.rq_a[gnt_id];
                  b_q      <= sif.rq_b[gnt_id];
                  sub_q    <= sif.rq_sub[gnt_id];
                  rm_q     <= sif.rq_rm[gnt_id];
                  rsp_id_q <= gnt_id;
                  cnt_q    <= CNT_INIT;
               end
            end
            ST_EXEC: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  res_q       <= '{es: sif.add_es, fs: sif.add_fs,
                                   ss: sif.add_ss, fls: sif.add_fls};
                  rsp_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (sif.rsp_ready) rsp_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign sif.rq_ready  = gnt;
   assign sif.add_a     = a_q;
   assign sif.add_b     = b_q;
   assign sif.add_sub   = sub_q;
   assign sif.add_rm    = rm_q;
   assign sif.rsp_valid = rsp_valid_q;
   assign sif.rsp_id    = rsp_id_q;
   assign sif.rsp_es    = res_q.es;
   assign sif.rsp_fs    = res_q.fs;
   assign sif.rsp_ss    = res_q.ss;
   assign sif.rsp_fls   = res_q.fls;
   assign sif.busy      = !idle;
   assign sif.state_dbg = state_q;

endmodule

// File: tb/tb_fpu_add_sched.sv
// ---------------------------------------------------------------------------
// tb_fpu_add_sched
// Directed bench for fpu_add_sched: one instance with LAT=1, one with LAT=4.
// Each instance is fed by a toy adder that only handles equal-exponent
// operands; for LAT=4 its result only appears three cycles after add_*
// change, so an early capture sees stale data.
// ---------------------------------------------------------------------------
module tb_fpu_add_sched;
   import fpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fpu_add_sched_if if1 ();
   fpu_add_sched_if if4 ();

   fpu_add_sched #(.LAT(1), .NREQ(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .sif(if1.slave));
   fpu_add_sched #(.LAT(4), .NREQ(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .sif(if4.slave));

   // ---------------- toy adder ----------------
   function automatic fpu_res_t adder_ref(input fpu_op_t a, input fpu_op_t b,
                                          input logic sub, input logic [1:0] rm);
      fpu_res_t    r;
      logic [53:0] m;
      r = '0;
      if (!(sub ^ a.sa ^ b.sa)) begin
         m    = {1'b0, a.fa} + {1'b0, b.fa};
         r.es = a.ea + {10'b0, m[53]};
         r.fs = {m, 3'b000};
         r.ss = a.sa;
      end else begin
         m = {1'b0, a.fa} - {1'b0, b.fa};
         if (m == '0) begin
            r.ss           = (rm == RM_RDN);
            r.fls[FLS_ZERO] = 1'b1;
         end else begin
            r.es = a.ea;
            r.fs = {m, 3'b000};
            r.ss = a.sa;
         end
      end
      return r;
   endfunction

   fpu_res_t m1;
   always_comb m1 = adder_ref(if1.add_a, if1.add_b, if1.add_sub, if1.add_rm);
   assign if1.add_es  = m1.es;
   assign if1.add_fs  = m1.fs;
   assign if1.add_ss  = m1.ss;
   assign if1.add_fls = m1.fls;

   fpu_res_t m4_c, m4_s1, m4_s2, m4_s3;
   always_comb m4_c = adder_ref(if4.add_a, if4.add_b, if4.add_sub, if4.add_rm);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m4_s1 <= '0;
         m4_s2 <= '0;
         m4_s3 <= '0;
      end else begin
         m4_s1 <= m4_c;
         m4_s2 <= m4_s1;
         m4_s3 <= m4_s2;
      end
   end
   assign if4.add_es  = m4_s3.es;
   assign if4.add_fs  = m4_s3.fs;
   assign if4.add_ss  = m4_s3.ss;
   assign if4.add_fls = m4_s3.fls;

   // ---------------- operands and hand-computed results ----------------
   localparam fpu_op_t ONE  = '{sa: 1'b0, ea: 11'h3FF, fa: 53'h10_0000_0000_0000, fla: 4'h0};
   localparam fpu_op_t ONE5 = '{sa: 1'b0, ea: 11'h3FF, fa: 53'h18_0000_0000_0000, fla: 4'h0};
   localparam fpu_op_t THREE = '{sa: 1'b0, ea: 11'h400, fa: 53'h18_0000_0000_0000, fla: 4'h0};

   localparam logic [56:0] FS_TWO   = 57'h100_0000_0000_0000; // 1.0 + 1.0
   localparam logic [56:0] FS_THREE = 57'h180_0000_0000_0000; // 1.5 + 1.5
   localparam logic [56:0] FS_2P5   = 57'h140_0000_0000_0000; // 1.0 + 1.5

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_rsp_valid"}, 128'(if1.rsp_valid), 128'(0));
      check({tag, "_busy"},      128'(if1.busy),      128'(0));
      check({tag, "_state"},     128'(if1.state_dbg), 128'(ST_IDLE));
      check({tag, "_add_a"},     128'(if1.add_a),     128'(0));
      check({tag, "_add_b"},     128'(if1.add_b),     128'(0));
      check({tag, "_add_sub"},   128'(if1.add_sub),   128'(0));
      check({tag, "_add_rm"},    128'(if1.add_rm),    128'(0));
      check({tag, "_rsp_id"},    128'(if1.rsp_id),    128'(0));
      check({tag, "_rsp_es"},    128'(if1.rsp_es),    128'(0));
      check({tag, "_rsp_fs"},    128'(if1.rsp_fs),    128'(0));
      check({tag, "_rsp_ss"},    128'(if1.rsp_ss),    128'(0));
      check({tag, "_rsp_fls"},   128'(if1.rsp_fls),   128'(0));
   endtask

   // ---------------- driver tasks (LAT=1 instance) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns at the negedge where rq_ready is first seen nonzero.
   task automatic wait_ready1(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (if1.rq_ready != 2'b00);
      end
      check({tag, "_ready_seen"}, 128'(seen), 128'(1));
   endtask

   task automatic wait_rsp1(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = if1.rsp_valid;
      end
      check({tag, "_rsp_seen"}, 128'(seen), 128'(1));
   endtask

   task automatic set_req1(input int id, input fpu_op_t a, input fpu_op_t b,
                           input logic sub, input logic [1:0] rm);
      if1.rq_a[id]   = a;
      if1.rq_b[id]   = b;
      if1.rq_sub[id] = sub;
      if1.rq_rm[id]  = rm;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int          last_cyc;
      logic [56:0] exp_fs;

      if1.rq_valid = 2'b00;  if4.rq_valid = 2'b00;
      if1.rq_a = '0;  if1.rq_b = '0;  if1.rq_sub = '0;  if1.rq_rm = '0;
      if4.rq_a = '0;  if4.rq_b = '0;  if4.rq_sub = '0;  if4.rq_rm = '0;
      if1.rsp_ready = 1'b0;  if4.rsp_ready = 1'b0;
      last_cyc = 0;

      // Reset state.
      #12;
      check_zero_outputs("reset");
      check("reset_rq_ready", 128'(if1.rq_ready), 128'(0));
      check("reset4_busy", 128'(if4.busy), 128'(0));
      tick();
      rst_n = 1'b1;

      // Single request on requester 0, LAT=1: 1.0 + 1.0.
      tick();
      set_req1(0, ONE, ONE, 1'b0, RM_RNE);
      if1.rq_valid = 2'b01;
      #1;
      check("single_rq_ready", 128'(if1.rq_ready), 128'(2'b01));
      tick();                                   // accept edge
      if1.rq_valid = 2'b00;
      check("single_add_a",    128'(if1.add_a),     128'(ONE));
      check("single_add_b",    128'(if1.add_b),     128'(ONE));
      check("single_add_sub",  128'(if1.add_sub),   128'(0));
      check("single_ready_off",128'(if1.rq_ready),  128'(0));
      check("single_busy",     128'(if1.busy),      128'(1));
      check("single_exec",     128'(if1.state_dbg), 128'(ST_EXEC));
      check("single_no_rsp",   128'(if1.rsp_valid), 128'(0));
      tick();                                   // accept + 1
      check("single_rsp_valid",128'(if1.rsp_valid), 128'(1));
      check("single_rsp_id",   128'(if1.rsp_id),    128'(0));
      check("single_rsp_es",   128'(if1.rsp_es),    128'(11'h400));
      check("single_rsp_fs",   128'(if1.rsp_fs),    128'(FS_TWO));
      check("single_rsp_ss",   128'(if1.rsp_ss),    128'(0));
      check("single_rsp_fls",  128'(if1.rsp_fls),   128'(0));
      if1.rsp_ready = 1'b1;
      tick();
      check("single_rsp_drop", 128'(if1.rsp_valid), 128'(0));
      check("single_idle",     128'(if1.busy),      128'(0));
      check("single_add_kept", 128'(if1.add_a),     128'(ONE));

      // Fresh pointer, then both requesters held: grants 0,1,0,1.
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      set_req1(0, ONE,  ONE,  1'b0, RM_RNE);
      set_req1(1, ONE5, ONE5, 1'b0, RM_RNE);
      if1.rq_valid = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_ready1("rr");
         check($sformatf("rr_grant%0d", n), 128'(if1.rq_ready),
               128'((n % 2 == 0) ? 2'b01 : 2'b10));
         if (n > 0) check($sformatf("rr_interval%0d", n), 128'(cyc - last_cyc), 128'(3));
         last_cyc = cyc;
         wait_rsp1("rr");
         exp_fs = (n % 2 == 0) ? FS_TWO : FS_THREE;
         check($sformatf("rr_rsp_id%0d", n), 128'(if1.rsp_id), 128'(n % 2));
         check($sformatf("rr_rsp_fs%0d", n), 128'(if1.rsp_fs), 128'(exp_fs));
      end
      tick();
      if1.rq_valid = 2'b00;

      // Back-pressure: response held 5 cycles with both requesting.
      tick();
      if1.rsp_ready = 1'b0;
      if1.rq_valid  = 2'b11;
      wait_ready1("bp");
      check("bp_grant", 128'(if1.rq_ready), 128'(2'b01));
      wait_rsp1("bp");
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_valid%0d", k), 128'(if1.rsp_valid), 128'(1));
         check($sformatf("bp_fs%0d", k),    128'(if1.rsp_fs),    128'(FS_TWO));
         check($sformatf("bp_id%0d", k),    128'(if1.rsp_id),    128'(0));
         check($sformatf("bp_ready%0d", k), 128'(if1.rq_ready),  128'(0));
         check($sformatf("bp_busy%0d", k),  128'(if1.busy),      128'(1));
         @(negedge clk);
      end
      tick();
      if1.rsp_ready = 1'b1;
      tick();                                   // response handshake edge
      check("bp_idle",       128'(if1.state_dbg), 128'(ST_IDLE));
      check("bp_rsp_drop",   128'(if1.rsp_valid), 128'(0));
      check("bp_next_grant", 128'(if1.rq_ready),  128'(2'b10));
      if1.rq_valid = 2'b00;                     // withdraw before any accept

      // Pointer must still favour requester 1; subtract 3.0 - 3.0, RDN.
      tick();
      set_req1(0, ONE,   ONE,   1'b0, RM_RNE);
      set_req1(1, THREE, THREE, 1'b1, RM_RDN);
      if1.rq_valid = 2'b11;
      wait_ready1("sub");
      check("sub_ptr_kept", 128'(if1.rq_ready), 128'(2'b10));
      tick();
      if1.rq_valid = 2'b00;
      check("sub_add_sub", 128'(if1.add_sub), 128'(1));
      check("sub_add_rm",  128'(if1.add_rm),  128'(RM_RDN));
      check("sub_add_a",   128'(if1.add_a),   128'(THREE));
      wait_rsp1("sub");
      check("sub_rsp_id",  128'(if1.rsp_id),  128'(1));
      check("sub_rsp_es",  128'(if1.rsp_es),  128'(0));
      check("sub_rsp_fs",  128'(if1.rsp_fs),  128'(0));
      check("sub_rsp_ss",  128'(if1.rsp_ss),  128'(1));
      check("sub_rsp_fls", 128'(if1.rsp_fls), 128'(1));
      tick();

      // Reset while in EXEC (requester 1 so rsp_id is nonzero beforehand).
      set_req1(1, ONE, ONE, 1'b0, RM_RNE);
      if1.rq_valid = 2'b10;
      wait_ready1("rst_exec");
      tick();
      if1.rq_valid = 2'b00;
      check("rst_exec_state", 128'(if1.state_dbg), 128'(ST_EXEC));
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("rst_exec");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset while in DONE (requester 0 moves the pointer to 1 first).
      tick();
      if1.rsp_ready = 1'b0;
      set_req1(0, ONE5, ONE5, 1'b0, RM_RNE);
      if1.rq_valid = 2'b01;
      wait_ready1("rst_done");
      tick();
      if1.rq_valid = 2'b00;
      tick();
      check("rst_done_valid", 128'(if1.rsp_valid), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("rst_done");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      if1.rq_valid = 2'b11;
      #1;
      check("rst_first_grant", 128'(if1.rq_ready), 128'(2'b01));
      if1.rq_valid = 2'b00;

      // LAT=4: capture exactly 4 edges after accept; add_* ignore rq_a changes.
      tick();
      if4.rq_a[0] = ONE;
      if4.rq_b[0] = ONE5;
      if4.rq_valid = 2'b01;
      #1;
      check("lat4_rq_ready", 128'(if4.rq_ready), 128'(2'b01));
      tick();                                   // accept edge k
      if4.rq_valid = 2'b00;
      if4.rq_a[0]  = THREE;
      if4.rq_b[0]  = THREE;
      check("lat4_add_a_k", 128'(if4.add_a), 128'(ONE));
      for (int j = 1; j <= 3; j++) begin
         tick();
         check($sformatf("lat4_no_rsp_k%0d", j), 128'(if4.rsp_valid), 128'(0));
         check($sformatf("lat4_add_a_k%0d", j),  128'(if4.add_a),     128'(ONE));
         check($sformatf("lat4_add_b_k%0d", j),  128'(if4.add_b),     128'(ONE5));
      end
      tick();                                   // edge k+4
      check("lat4_rsp_valid", 128'(if4.rsp_valid), 128'(1));
      check("lat4_rsp_es",    128'(if4.rsp_es),    128'(11'h400));
      check("lat4_rsp_fs",    128'(if4.rsp_fs),    128'(FS_2P5));
      check("lat4_rsp_id",    128'(if4.rsp_id),    128'(0));
      check("lat4_state",     128'(if4.state_dbg), 128'(ST_DONE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
